// File: rtl/vc_fifo_bank.sv
// rtl/vc_fifo_bank.sv - per-port virtual-channel input buffer, NUM_VC FIFOs of DEPTH flits
// Optional feature macro: VC_FIFO_CREDIT_EN (registered per-VC credit return pulses)
module vc_fifo_bank #(
  parameter int FLIT_W = 8,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  input  logic [$clog2(NUM_VC)-1:0]           wr_vc,
  input  logic [FLIT_W-1:0]                   flit_in,
  input  logic                                rd_en,
  input  logic [$clog2(NUM_VC)-1:0]           rd_vc,
  output logic [NUM_VC*FLIT_W-1:0]            head_flat,
  output logic [NUM_VC-1:0]                   vc_empty,
  output logic [NUM_VC-1:0]                   vc_full,
  output logic [NUM_VC*$clog2(DEPTH+1)-1:0]   vc_count_flat,
  output logic [NUM_VC-1:0]                   ovf_err,
  output logic [NUM_VC-1:0]                   unf_err
`ifdef VC_FIFO_CREDIT_EN
  ,
  output logic [NUM_VC-1:0]                   credit_ret
`endif
);

  localparam int VC_W  = $clog2(NUM_VC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Storage is deliberately left unreset; count gates every read of it.
  logic [FLIT_W-1:0] mem_q    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]  count_q  [NUM_VC];
  logic [CNT_W-1:0]  count_d  [NUM_VC];
  logic [NUM_VC-1:0] ovf_q, ovf_d;
  logic [NUM_VC-1:0] unf_q, unf_d;
  logic [NUM_VC-1:0] wr_sel, rd_sel, wr_ok, pop_ok;

  // Per-VC decode of write/pop legality and next pointer/count/flag state.
  // Out-of-range VC indices match no channel, so they are silently ignored.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    wr_ok  = '0;
    pop_ok = '0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    for (int i = 0; i < NUM_VC; i++) begin
      wr_sel[i] = wr_valid && (wr_vc == VC_W'(i));
      rd_sel[i] = rd_en && (rd_vc == VC_W'(i));
      // A same-cycle write never rescues a pop on an empty VC.
      pop_ok[i] = rd_sel[i] && (count_q[i] != '0);
      // A full VC still accepts when its head is being popped this cycle.
      wr_ok[i]  = wr_sel[i] && ((count_q[i] != CNT_W'(DEPTH)) || rd_sel[i]);
      if (wr_sel[i] && !wr_ok[i]) ovf_d[i] = 1'b1;
      if (rd_sel[i] && !pop_ok[i]) unf_d[i] = 1'b1;
      wr_ptr_d[i] = wr_ok[i]  ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_ok[i] ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (wr_ok[i] && !pop_ok[i]) count_d[i] = count_q[i] + CNT_W'(1);
      else if (!wr_ok[i] && pop_ok[i]) count_d[i] = count_q[i] - CNT_W'(1);
    end
  end

  // Status and fall-through head outputs, derived purely from registered state.
  always_comb begin
    head_flat     = '0;
    vc_empty      = '0;
    vc_full       = '0;
    vc_count_flat = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      vc_empty[i] = (count_q[i] == '0);
      vc_full[i]  = (count_q[i] == CNT_W'(DEPTH));
      vc_count_flat[i*CNT_W +: CNT_W] = count_q[i];
      if (count_q[i] != '0) head_flat[i*FLIT_W +: FLIT_W] = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Pointer, occupancy and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Flit storage write port, one accepted flit per cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (wr_ok[i]) mem_q[i][wr_ptr_q[i]] <= flit_in;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

`ifdef VC_FIFO_CREDIT_EN
  logic [NUM_VC-1:0] credit_q;

  // One-cycle credit pulse following every accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) credit_q <= '0;
    else      credit_q <= pop_ok;
  end

  assign credit_ret = credit_q;
`endif

endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb/tb_vc_fifo_bank.sv - randomized queue-model bench for vc_fifo_bank (NUM_VC=2, DEPTH=4, FLIT_W=8)
module tb_vc_fifo_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [0:0]  wr_vc;
  logic [7:0]  flit_in;
  logic        rd_en;
  logic [0:0]  rd_vc;
  logic [15:0] head_flat;
  logic [1:0]  vc_empty, vc_full;
  logic [5:0]  vc_count_flat;
  logic [1:0]  ovf_err, unf_err;
`ifdef VC_FIFO_CREDIT_EN
  logic [1:0]  credit_ret;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  vc_fifo_bank #(.FLIT_W(8), .NUM_VC(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_vc(wr_vc), .flit_in(flit_in),
    .rd_en(rd_en), .rd_vc(rd_vc), .head_flat(head_flat), .vc_empty(vc_empty),
    .vc_full(vc_full), .vc_count_flat(vc_count_flat), .ovf_err(ovf_err), .unf_err(unf_err)
`ifdef VC_FIFO_CREDIT_EN
    , .credit_ret(credit_ret)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per VC plus sticky flags and credit pulses.
  logic [7:0] mq [2][$];
  logic [1:0] m_ovf, m_unf, m_cred;

  always @(posedge clk or negedge rst) begin
    bit ws, rs, pop, wr;
    int sz;
    if (!rst) begin
      for (int v = 0; v < 2; v++) mq[v].delete();
      m_ovf = 2'b00;
      m_unf = 2'b00;
      m_cred = 2'b00;
    end else begin
      for (int v = 0; v < 2; v++) begin
        ws  = wr_valid && (int'(wr_vc) == v);
        rs  = rd_en && (int'(rd_vc) == v);
        sz  = mq[v].size();
        pop = rs && (sz > 0);
        wr  = ws && ((sz < 4) || rs);
        if (rs && sz == 0) m_unf[v] = 1'b1;
        if (ws && !wr) m_ovf[v] = 1'b1;
        if (pop) void'(mq[v].pop_front());
        if (wr) mq[v].push_back(flit_in);
        m_cred[v] = pop;
      end
    end
  end

  // Compare process: every falling edge out of reset, all outputs vs model.
  always @(negedge clk) begin
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        chk($sformatf("count%0d", v), 32'(vc_count_flat[v*3 +: 3]), 32'(mq[v].size()));
        chk($sformatf("empty%0d", v), 32'(vc_empty[v]), 32'(mq[v].size() == 0));
        chk($sformatf("full%0d", v), 32'(vc_full[v]), 32'(mq[v].size() == 4));
        chk($sformatf("head%0d", v), 32'(head_flat[v*8 +: 8]),
            (mq[v].size() > 0) ? 32'(mq[v][0]) : 32'h0);
        chk($sformatf("ovf%0d", v), 32'(ovf_err[v]), 32'(m_ovf[v]));
        chk($sformatf("unf%0d", v), 32'(unf_err[v]), 32'(m_unf[v]));
`ifdef VC_FIFO_CREDIT_EN
        chk($sformatf("credit%0d", v), 32'(credit_ret[v]), 32'(m_cred[v]));
`endif
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input logic wv, input logic [0:0] wvc, input logic [7:0] d,
                      input logic re, input logic [0:0] rvc);
    wr_valid = wv; wr_vc = wvc; flit_in = d; rd_en = re; rd_vc = rvc;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(vc_empty), 32'h3);
    chk({tag, "_full"},  32'(vc_full), 32'h0);
    chk({tag, "_count"}, 32'(vc_count_flat), 32'h0);
    chk({tag, "_head"},  32'(head_flat), 32'h0);
    chk({tag, "_errs"},  32'({ovf_err, unf_err}), 32'h0);
  endtask

  task automatic fill_vc0();
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 0, 8'h44, 0, 0);
  endtask

  initial begin
    int rd_pct;
    rst = 1'b0; wr_valid = 1'b0; wr_vc = '0; flit_in = '0; rd_en = 1'b0; rd_vc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("in_reset");
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    chk_reset_vals("idle");

    // Fill VC0, then overflow it.
    step(1, 0, 8'h11, 0, 0);
    chk("first_wr_head0", 32'(head_flat[7:0]), 32'h11);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 0, 8'h44, 0, 0);
    chk("fill_full0", 32'(vc_full[0]), 32'h1);
    chk("fill_count0", 32'(vc_count_flat[2:0]), 32'h4);
    step(1, 0, 8'h55, 0, 0);
    chk("ovf_set0", 32'(ovf_err[0]), 32'h1);
    chk("ovf_count0", 32'(vc_count_flat[2:0]), 32'h4);

    // Drain VC0 and underflow it.
    chk("drain_h0", 32'(head_flat[7:0]), 32'h11); step(0, 0, 0, 1, 0);
    chk("drain_h1", 32'(head_flat[7:0]), 32'h22); step(0, 0, 0, 1, 0);
    chk("drain_h2", 32'(head_flat[7:0]), 32'h33); step(0, 0, 0, 1, 0);
    chk("drain_h3", 32'(head_flat[7:0]), 32'h44); step(0, 0, 0, 1, 0);
    chk("drain_empty0", 32'(vc_empty[0]), 32'h1);
    step(0, 0, 0, 1, 0);
    chk("unf_set0", 32'(unf_err[0]), 32'h1);
    chk("unf_vc1_clean", 32'({unf_err[1], ovf_err[1], vc_count_flat[5:3]}), 32'h0);

    // Full VC0 with simultaneous write and pop.
    do_reset();
    fill_vc0();
    step(1, 0, 8'hAA, 1, 0);
    chk("wp_count0", 32'(vc_count_flat[2:0]), 32'h4);
    chk("wp_ovf0", 32'(ovf_err[0]), 32'h0);
    chk("wp_h0", 32'(head_flat[7:0]), 32'h22); step(0, 0, 0, 1, 0);
    chk("wp_h1", 32'(head_flat[7:0]), 32'h33); step(0, 0, 0, 1, 0);
    chk("wp_h2", 32'(head_flat[7:0]), 32'h44); step(0, 0, 0, 1, 0);
    chk("wp_h3", 32'(head_flat[7:0]), 32'hAA); step(0, 0, 0, 1, 0);

    // Interleave: write VC1 while popping VC0, then the reverse, with wrap.
    fill_vc0();
    for (int k = 0; k < 6; k++) step(1, 1, 8'hB1 + 8'(k), 1, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 8'hC1 + 8'(k), 1, 1);
    chk("il_count1", 32'(vc_count_flat[5:3]), 32'h0);
    chk("il_count0", 32'(vc_count_flat[2:0]), 32'h4);

`ifdef VC_FIFO_CREDIT_EN
    do_reset();
    step(1, 1, 8'h01, 0, 0);
    step(1, 1, 8'h02, 0, 0);
    step(1, 1, 8'h03, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 1);
      chk("credit_pulse", 32'(credit_ret), 32'h2);
      step(0, 0, 0, 0, 0);
      chk("credit_idle", 32'(credit_ret), 32'h0);
    end
`endif

    // Asynchronous reset in the middle of a drain with a write in flight.
    do_reset();
    fill_vc0();
    step(1, 1, 8'h77, 1, 0);
    wr_valid = 1'b1; wr_vc = 1'b1; flit_in = 8'h99; rd_en = 1'b1; rd_vc = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("async_rst");
`ifdef VC_FIFO_CREDIT_EN
    chk("async_rst_credit", 32'(credit_ret), 32'h0);
`endif
    @(posedge clk); #1;
    chk_reset_vals("held_rst");
    wr_valid = 1'b0; rd_en = 1'b0;
    rst = 1'b1;

    // Randomized traffic with varying pop pressure.
    for (int ph = 0; ph < 6; ph++) begin
      rd_pct = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 50 : 80);
      for (int n = 0; n < 500; n++) begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(0, 99) < rd_pct, 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_fifo_bank.md
Name: vc_fifo_bank

Overview:
- Parametrised virtual-channel input buffer for one router input port.
- Holds NUM_VC independent FIFOs of DEPTH flits each. Replaces the single-entry-per-VC buffer scheme.
- Upstream link writes one flit per cycle into the VC named by wr_vc. The switch allocator pops one flit per cycle from the VC named by rd_vc.
- Per-VC occupancy, full/empty status and sticky error flags feed flow control and debug.

Parameters:
- FLIT_W, 8: flit width in bits.
- NUM_VC, 2: number of virtual channels; must be ≥2. VC_W = $clog2(NUM_VC).
- DEPTH, 4: entries per VC; power of two, ≥2. PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  flit_in is valid this cycle.
- wr_vc  in  VC_W  target VC for flit_in.
- flit_in  in  FLIT_W  incoming flit.
- rd_en  in  1  pop head of VC rd_vc this cycle.
- rd_vc  in  VC_W  VC to pop.
- head_flat  out  NUM_VC*FLIT_W  head flit of each VC; VC i occupies bits [i*FLIT_W +: FLIT_W].
- vc_empty  out  NUM_VC  per-VC empty.
- vc_full  out  NUM_VC  per-VC full.
- vc_count_flat  out  NUM_VC*CNT_W  per-VC occupancy.
- ovf_err  out  NUM_VC  sticky: write rejected on full VC.
- unf_err  out  NUM_VC  sticky: pop attempted on empty VC.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pointers, counts, ovf_err and unf_err go to 0.
  - vc_empty = all 1s, vc_full = 0, head_flat = 0.
  - Storage array is not reset.
- Per-VC state: wr_ptr, rd_ptr (PTR_W bits, wrap DEPTH-1 → 0), count (0..DEPTH).
- vc_empty[i] = (count==0); vc_full[i] = (count==DEPTH). Both are combinational from count.
- First-word fall-through:
  - head_flat slice i = mem[i][rd_ptr[i]] when count>0, else all zeros.
  - A flit written in cycle N appears on head in cycle N+1, i.e. one clock of write-to-head latency.
- Write acceptance: wr_valid && (!vc_full[wr_vc] || (rd_en && rd_vc==wr_vc)).
  - An accepted write stores flit_in at wr_ptr and increments wr_ptr.
- Write rejection: wr_valid on a full VC with no same-VC pop.
  - Flit is dropped, state is unchanged, ovf_err[wr_vc] is set.
- Pop acceptance: rd_en && !vc_empty[rd_vc].
  - Increments rd_ptr; head_flat updates next cycle.
  - rd_en on an empty VC: no state change, unf_err[rd_vc] is set.
  - A write in the same cycle to an empty VC does not make that pop legal.
- Count update per VC: +1 on accepted write only, −1 on accepted pop only, unchanged when both or neither occur.
- Writes and pops to different VCs in the same cycle are independent.
- wr_vc or rd_vc ≥ NUM_VC (non-power-of-two NUM_VC): operation ignored, no flag set.
- Error flags are sticky until reset.
- Reset asserted mid-stream: all VCs are empty immediately, regardless of any in-flight write or pop.
- No combinational path from wr_valid/flit_in to any output.

Optional Feature:
- Macro: VC_FIFO_CREDIT_EN.
- When defined:
  - Adds output credit_ret (NUM_VC bits, registered).
  - credit_ret[i] pulses high for exactly one cycle, the cycle after each accepted pop from VC i.
  - Reset value is 0.
  - This lets the upstream router maintain per-VC credit counters initialised to DEPTH.
- When not defined: the port is absent, and no credit logic is synthesised.

Test Plan:
Test parameters are NUM_VC=2, DEPTH=4, FLIT_W=8.
- Reset then idle:
  - vc_empty=2'b11, vc_full=0, counts 0, head_flat=16'h0000.
- Fill VC0 with 8'h11, 8'h22, 8'h33, 8'h44:
  - after the 4th write, vc_full[0]=1 and count0=4; head0=8'h11 one cycle after the first write.
  - a 5th write of 8'h55 sets ovf_err[0] and count stays 4.
- Drain VC0 with 4 pops:
  - head0 sequence 11,22,33,44; vc_empty[0]=1 after the last pop.
  - a 5th pop sets unf_err[0] and leaves VC1 untouched.
- VC0 full, same-cycle write 8'hAA plus pop of VC0:
  - write accepted, count0 stays 4, ovf_err[0] stays 0.
  - subsequent drain yields 22,33,44,AA.
- Interleave: write VC1 8'hB1 while popping VC0 over 6 cycles with wrap-around (≥DEPTH+2 ops per VC):
  - data order is preserved per VC, and counts match a reference model each cycle.
- With VC_FIFO_CREDIT_EN: 3 pops on VC1 produce 3 single-cycle credit_ret[1] pulses, each one cycle after its pop. Assert rst low mid-drain: all outputs return to reset values asynchronously.
